// File: rtl/mul_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared definitions for the hard-wired control sequencer:
//                opcode constants, sequencer state encoding, IR field bit
//                positions and the packed control-strobe bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Opcodes that the sequencer executes; every other value runs as a NOP
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // IR field positions
    localparam int OPC_HI = 31;
    localparam int OPC_LO = 27;
    localparam int RA_HI  = 26;
    localparam int RA_LO  = 23;
    localparam int RB_HI  = 22;
    localparam int RB_LO  = 19;
    localparam int RC_HI  = 18;
    localparam int RC_LO  = 15;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_HALT = 4'd8
    } state_t;

    // One cycle's worth of datapath control
    typedef struct packed {
        logic       pc_out;
        logic       mar_in;
        logic       inc_pc;
        logic       z_in;
        logic       pc_in;
        logic       read;
        logic       mdr_in;
        logic       mdr_out;
        logic       ir_in;
        logic       y_in;
        logic       zlow_out;
        logic       zhigh_out;
        logic       lo_in;
        logic       hi_in;
        logic       gra;
        logic       grb;
        logic       grc;
        logic       r_in;
        logic       r_out;
        logic [4:0] alu_op;
    } strobes_t;

    // Two-operand register ALU instruction that writes back through Gra
    function automatic logic is_alu(input logic [4:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    endfunction

    // Instruction whose result lands in the HI/LO pair
    function automatic logic is_muldiv(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mul_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mul_seq_ctrl_if
//  Description : Control bus between the sequencer and the datapath.
//                master : sequencer (reads run/ir, drives strobes and status)
//                slave  : datapath / environment (drives run/ir)
//  Ports       : run, ir in; PCout..HIin, Gra/Grb/Grc, Rin/Rout, alu_op,
//                busy, halted, instr_cnt out (from the master's view)
//  Revision    : 1.0 - initial release
// ============================================================================
interface mul_seq_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             run;
    logic [31:0]      ir;

    logic             PCout;
    logic             MARin;
    logic             IncPC;
    logic             Zin;
    logic             PCin;
    logic             Read;
    logic             MDRin;
    logic             MDRout;
    logic             IRin;
    logic             Yin;
    logic             Zlowout;
    logic             Zhighout;
    logic             LOin;
    logic             HIin;
    logic             Gra;
    logic             Grb;
    logic             Grc;
    logic             Rin;
    logic             Rout;
    logic [4:0]       alu_op;
    logic             busy;
    logic             halted;
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        input  run, ir,
        output PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout, IRin, Yin,
               Zlowout, Zhighout, LOin, HIin, Gra, Grb, Grc, Rin, Rout,
               alu_op, busy, halted, instr_cnt
    );

    modport slave (
        output run, ir,
        input  PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout, IRin, Yin,
               Zlowout, Zhighout, LOin, HIin, Gra, Grb, Grc, Rin, Rout,
               alu_op, busy, halted, instr_cnt
    );

endinterface
`default_nettype wire

// File: rtl/mul_seq_ctrl_seq_decode.sv
`default_nettype none
// ============================================================================
//  Module      : seq_decode
//  Description : Purely combinational decode of (state, opcode) into the
//                per-cycle strobe bundle, the next state assuming run stays
//                high, and a retire flag for the cycle that completes an
//                instruction.
//  Ports       : state, opcode in; strb, nxt_hint, retire out
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_decode
    import cpu_pkg::*;
(
    input  state_t     state,
    input  logic [4:0] opcode,
    output strobes_t   strb,
    output state_t     nxt_hint,
    output logic       retire
);

    logic w_alu;
    logic w_muldiv;

    assign w_alu    = is_alu(opcode);
    assign w_muldiv = is_muldiv(opcode);

    always_comb begin
        strb     = '0;
        nxt_hint = state;
        retire   = 1'b0;

        unique case (state)
            S_IDLE: begin
                nxt_hint = S_T0;
            end
            S_T0: begin
                strb.pc_out = 1'b1;
                strb.mar_in = 1'b1;
                strb.inc_pc = 1'b1;
                strb.z_in   = 1'b1;
                nxt_hint    = S_T1;
            end
            S_T1: begin
                strb.zlow_out = 1'b1;
                strb.pc_in    = 1'b1;
                strb.read     = 1'b1;
                strb.mdr_in   = 1'b1;
                nxt_hint      = S_T2;
            end
            S_T2: begin
                strb.mdr_out = 1'b1;
                strb.ir_in   = 1'b1;
                nxt_hint     = S_T3;
            end
            S_T3: begin
                // IR was loaded at the end of T2, so the opcode is valid here
                if (opcode == OP_HALT) begin
                    nxt_hint = S_HALT;
                end else if (w_alu || w_muldiv) begin
                    strb.grb   = 1'b1;
                    strb.r_out = 1'b1;
                    strb.y_in  = 1'b1;
                    nxt_hint   = S_T4;
                end else begin
                    retire   = 1'b1;
                    nxt_hint = S_T0;
                end
            end
            S_T4: begin
                strb.grc    = 1'b1;
                strb.r_out  = 1'b1;
                strb.z_in   = 1'b1;
                strb.alu_op = opcode;
                nxt_hint    = S_T5;
            end
            S_T5: begin
                strb.zlow_out = 1'b1;
                if (w_muldiv) begin
                    strb.lo_in = 1'b1;
                    nxt_hint   = S_T6;
                end else begin
                    strb.gra  = 1'b1;
                    strb.r_in = 1'b1;
                    retire    = 1'b1;
                    nxt_hint  = S_T0;
                end
            end
            S_T6: begin
                strb.zhigh_out = 1'b1;
                strb.hi_in     = 1'b1;
                retire         = 1'b1;
                nxt_hint       = S_T0;
            end
            S_HALT: begin
                nxt_hint = S_HALT;
            end
            default: begin
                nxt_hint = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mul_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mul_seq_ctrl
//  Description : Hard-wired control sequencer. Walks fetch (T0-T2) and
//                register-register ALU / MUL / DIV execution (T3-T6),
//                counts retired instructions and stops in HALT until clr.
//  Ports       : clk, clr (async, active high), bus (mul_seq_ctrl_if.master)
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_seq_ctrl
    import cpu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  wire            clk,
    input  wire            clr,
    mul_seq_ctrl_if.master bus
);

    state_t           r_state;
    state_t           w_next;
    state_t           w_hint;
    strobes_t         w_strb;
    strobes_t         w_strb_q;
    logic             w_retire;
    logic [4:0]       w_opcode;
    logic [CNT_W-1:0] r_cnt;

    assign w_opcode = bus.ir[OPC_HI:OPC_LO];

    seq_decode u_decode (
        .state    (r_state),
        .opcode   (w_opcode),
        .strb     (w_strb),
        .nxt_hint (w_hint),
        .retire   (w_retire)
    );

    // run is only consulted in IDLE and on the retire cycle, so dropping
    // it mid-instruction lets the instruction finish.
    always_comb begin
        w_next = w_hint;
        if ((r_state == S_IDLE || w_retire) && !bus.run) begin
            w_next = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // clr also masks combinationally so strobes drop in the same cycle
    // clr rises, independent of when the asynchronous reset settles.
    assign w_strb_q = clr ? '0 : w_strb;

    assign bus.PCout     = w_strb_q.pc_out;
    assign bus.MARin     = w_strb_q.mar_in;
    assign bus.IncPC     = w_strb_q.inc_pc;
    assign bus.Zin       = w_strb_q.z_in;
    assign bus.PCin      = w_strb_q.pc_in;
    assign bus.Read      = w_strb_q.read;
    assign bus.MDRin     = w_strb_q.mdr_in;
    assign bus.MDRout    = w_strb_q.mdr_out;
    assign bus.IRin      = w_strb_q.ir_in;
    assign bus.Yin       = w_strb_q.y_in;
    assign bus.Zlowout   = w_strb_q.zlow_out;
    assign bus.Zhighout  = w_strb_q.zhigh_out;
    assign bus.LOin      = w_strb_q.lo_in;
    assign bus.HIin      = w_strb_q.hi_in;
    assign bus.Gra       = w_strb_q.gra;
    assign bus.Grb       = w_strb_q.grb;
    assign bus.Grc       = w_strb_q.grc;
    assign bus.Rin       = w_strb_q.r_in;
    assign bus.Rout      = w_strb_q.r_out;
    assign bus.alu_op    = w_strb_q.alu_op;

    assign bus.busy      = !clr && (r_state != S_IDLE) && (r_state != S_HALT);
    assign bus.halted    = !clr && (r_state == S_HALT);
    assign bus.instr_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mul_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_seq_ctrl
//  Description : Directed self-checking bench for mul_seq_ctrl. The driver
//                pushes the expected per-cycle outputs into a queue; a
//                monitor pops and compares on every falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_seq_ctrl;

    localparam logic [31:0] IR_MUL  = 32'h78918000;
    localparam logic [31:0] IR_AND  = 32'h28918000;
    localparam logic [31:0] IR_ADD  = 32'h18918000;
    localparam logic [31:0] IR_NOP  = 32'hF8000000;
    localparam logic [31:0] IR_HALT = 32'hD8000000;

    // Strobe bit positions in the packed comparison vector
    localparam logic [18:0] B_PCOUT    = 19'd1 << 18;
    localparam logic [18:0] B_MARIN    = 19'd1 << 17;
    localparam logic [18:0] B_INCPC    = 19'd1 << 16;
    localparam logic [18:0] B_ZIN      = 19'd1 << 15;
    localparam logic [18:0] B_PCIN     = 19'd1 << 14;
    localparam logic [18:0] B_READ     = 19'd1 << 13;
    localparam logic [18:0] B_MDRIN    = 19'd1 << 12;
    localparam logic [18:0] B_MDROUT   = 19'd1 << 11;
    localparam logic [18:0] B_IRIN     = 19'd1 << 10;
    localparam logic [18:0] B_YIN      = 19'd1 << 9;
    localparam logic [18:0] B_ZLOWOUT  = 19'd1 << 8;
    localparam logic [18:0] B_ZHIGHOUT = 19'd1 << 7;
    localparam logic [18:0] B_LOIN     = 19'd1 << 6;
    localparam logic [18:0] B_HIIN     = 19'd1 << 5;
    localparam logic [18:0] B_GRA      = 19'd1 << 4;
    localparam logic [18:0] B_GRB      = 19'd1 << 3;
    localparam logic [18:0] B_GRC      = 19'd1 << 2;
    localparam logic [18:0] B_RIN      = 19'd1 << 1;
    localparam logic [18:0] B_ROUT     = 19'd1 << 0;

    localparam logic [18:0] E_NONE = 19'd0;
    localparam logic [18:0] E_T0   = B_PCOUT | B_MARIN | B_INCPC | B_ZIN;
    localparam logic [18:0] E_T1   = B_ZLOWOUT | B_PCIN | B_READ | B_MDRIN;
    localparam logic [18:0] E_T2   = B_MDROUT | B_IRIN;
    localparam logic [18:0] E_T3   = B_GRB | B_ROUT | B_YIN;
    localparam logic [18:0] E_T4   = B_GRC | B_ROUT | B_ZIN;
    localparam logic [18:0] E_T5A  = B_ZLOWOUT | B_GRA | B_RIN;
    localparam logic [18:0] E_T5M  = B_ZLOWOUT | B_LOIN;
    localparam logic [18:0] E_T6   = B_ZHIGHOUT | B_HIIN;

    typedef struct {
        logic [18:0] s;
        logic [4:0]  alu;
        logic        busy;
        logic        halted;
        logic [15:0] cnt;
        string       nm;
    } exp_t;

    logic  clk;
    logic  clr;
    exp_t  q[$];
    int    n_pass;
    int    n_total;

    mul_seq_ctrl_if #(.CNT_W(16)) bus ();

    mul_seq_ctrl #(.CNT_W(16)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s.%s actual=%h expected=%h t=%0t", nm, fld, act, exp, $time);
    endtask

    // Monitor: the DUT presents a full output vector every cycle
    always @(negedge clk) begin
        exp_t        e;
        logic [18:0] act_s;
        if (q.size() > 0) begin
            e = q.pop_front();
            act_s = {bus.PCout, bus.MARin, bus.IncPC, bus.Zin, bus.PCin, bus.Read,
                     bus.MDRin, bus.MDRout, bus.IRin, bus.Yin, bus.Zlowout,
                     bus.Zhighout, bus.LOin, bus.HIin, bus.Gra, bus.Grb, bus.Grc,
                     bus.Rin, bus.Rout};
            chk(e.nm, "strobes", {13'd0, act_s}, {13'd0, e.s});
            chk(e.nm, "alu_op", {27'd0, bus.alu_op}, {27'd0, e.alu});
            chk(e.nm, "busy/halted", {30'd0, bus.busy, bus.halted}, {30'd0, e.busy, e.halted});
            chk(e.nm, "instr_cnt", {16'd0, bus.instr_cnt}, {16'd0, e.cnt});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_c(input logic [18:0] s, input logic [4:0] alu, input logic bz,
                            input logic hl, input logic [15:0] cnt, input string nm);
        exp_t e;
        e.s = s; e.alu = alu; e.busy = bz; e.halted = hl; e.cnt = cnt; e.nm = nm;
        q.push_back(e);
    endtask

    // Expect-then-advance for one cycle
    task automatic cyc(input logic [18:0] s, input logic [4:0] alu, input logic bz,
                       input logic hl, input logic [15:0] cnt, input string nm);
        expect_c(s, alu, bz, hl, cnt, nm);
        tick();
    endtask

    task automatic fetch(input logic [15:0] cnt, input string nm);
        cyc(E_T0, 5'd0, 1'b1, 1'b0, cnt, {nm, "_t0"});
        cyc(E_T1, 5'd0, 1'b1, 1'b0, cnt, {nm, "_t1"});
        cyc(E_T2, 5'd0, 1'b1, 1'b0, cnt, {nm, "_t2"});
    endtask

    task automatic alu_instr(input logic [4:0] op, input logic [15:0] cnt, input string nm);
        fetch(cnt, nm);
        cyc(E_T3,  5'd0, 1'b1, 1'b0, cnt, {nm, "_t3"});
        cyc(E_T4,  op,   1'b1, 1'b0, cnt, {nm, "_t4"});
        cyc(E_T5A, 5'd0, 1'b1, 1'b0, cnt, {nm, "_t5"});
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        clr     = 1'b1;
        bus.run = 1'b0;
        bus.ir  = 32'd0;
        tick();
        cyc(E_NONE, 5'd0, 1'b0, 1'b0, 16'd0, "reset");

        // MUL R1,R2,R3
        clr = 1'b0; bus.run = 1'b1; bus.ir = IR_MUL;
        cyc(E_NONE, 5'd0, 1'b0, 1'b0, 16'd0, "idle0");
        fetch(16'd0, "mul");
        cyc(E_T3,  5'd0,      1'b1, 1'b0, 16'd0, "mul_t3");
        cyc(E_T4,  5'b01111,  1'b1, 1'b0, 16'd0, "mul_t4");
        cyc(E_T5M, 5'd0,      1'b1, 1'b0, 16'd0, "mul_t5");
        cyc(E_T6,  5'd0,      1'b1, 1'b0, 16'd0, "mul_t6");

        // Two back-to-back ANDs
        bus.ir = IR_AND;
        alu_instr(5'b00101, 16'd1, "and1");
        alu_instr(5'b00101, 16'd2, "and2");

        // ADD with run dropped during T3: completes, then idles
        bus.ir = IR_ADD;
        fetch(16'd3, "add");
        cyc(E_T3, 5'd0, 1'b1, 1'b0, 16'd3, "add_t3");
        bus.run = 1'b0;
        cyc(E_T4,  5'b00011, 1'b1, 1'b0, 16'd3, "add_t4");
        cyc(E_T5A, 5'd0,     1'b1, 1'b0, 16'd3, "add_t5");
        cyc(E_NONE, 5'd0, 1'b0, 1'b0, 16'd4, "add_idle1");
        expect_c(E_NONE, 5'd0, 1'b0, 1'b0, 16'd4, "add_idle2");
        bus.run = 1'b1;
        tick();

        // Unknown opcode retires after an empty T3
        bus.ir = IR_NOP;
        fetch(16'd4, "nop");
        cyc(E_NONE, 5'd0, 1'b1, 1'b0, 16'd4, "nop_t3");

        // MUL interrupted by clr in the middle of T4
        bus.ir = IR_MUL;
        fetch(16'd5, "mclr");
        cyc(E_T3, 5'd0, 1'b1, 1'b0, 16'd5, "mclr_t3");
        #1;
        clr = 1'b1;
        expect_c(E_NONE, 5'd0, 1'b0, 1'b0, 16'd0, "mclr_t4_clr");
        tick();
        clr = 1'b0;
        cyc(E_NONE, 5'd0, 1'b0, 1'b0, 16'd0, "mclr_idle");

        // One AND, then HALT
        bus.ir = IR_AND;
        alu_instr(5'b00101, 16'd0, "and3");
        bus.ir = IR_HALT;
        fetch(16'd1, "halt");
        cyc(E_NONE, 5'd0, 1'b1, 1'b0, 16'd1, "halt_t3");
        for (int i = 0; i < 20; i++) begin
            cyc(E_NONE, 5'd0, 1'b0, 1'b1, 16'd1, "halted");
        end

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        n_total++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain actual=%0d expected=0 pending entries", q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Hard-wired control sequencer for the datapath. It generates the per-cycle control strobes for instruction fetch (T0–T2) and for register-register ALU, MUL and DIV execution (T3–T6).
- It replaces the hand-driven strobes used in the testbenches today, sits beside the datapath, and reads the IR contents back from it.
- It decodes the opcode and register fields from IR and drives register-select, bus-out, register-in and ALU-operation signals.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk, input, 1: system clock; all state changes on rising edge.
- clr, input, 1: asynchronous active-high reset.
- run, input, 1: level enable; sequencing starts and continues only while high.
- ir, input, 32: IR register contents from the datapath.
- PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout, IRin, Yin, Zlowout, Zhighout, LOin, HIin, output, 1 each: datapath strobes.
- Gra, Grb, Grc, output, 1 each: select the ra/rb/rc field of IR for register decode.
- Rin, Rout, output, 1 each: general-register write/read enable for the selected field.
- alu_op, output, 5: ALU operation code for the cycle; 0 means none.
- busy, output, 1: high in T0..T6.
- halted, output, 1: high in HALT.
- instr_cnt, output, CNT_W: retired-instruction count.

Behaviour:
- IR fields:
  - opcode = ir[31:27], ra = ir[26:23], rb = ir[22:19], rc = ir[18:15].
  - Example: 32'h28918000 decodes as AND R1, R2, R3.
- Opcodes: ADD=5'b00011, SUB=5'b00100, AND=5'b00101, OR=5'b00110, MUL=5'b01111, DIV=5'b10000, HALT=5'b11011. Any other value is a NOP.
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALT. State is a registered enum.
- Outputs are a Moore decode of state plus ir opcode. Every output is 0 in IDLE and HALT and while clr is high.
- IDLE: go to T0 when run=1, else stay.
- T0: PCout, MARin, IncPC, Zin. Go to T1.
- T1: Zlowout, PCin, Read, MDRin. Go to T2.
- T2: MDRout, IRin. IR is valid from the next cycle. Go to T3.
- T3 (reached only via T2):
  - HALT opcode: all strobes 0; go to HALT without executing.
  - NOP opcode: all strobes 0; retire.
  - ALU/MUL/DIV: Grb, Rout, Yin; go to T4.
- T4: Grc, Rout, Zin, alu_op = opcode. Go to T5.
- T5:
  - ADD/SUB/AND/OR: Zlowout, Gra, Rin; retire.
  - MUL/DIV: Zlowout, LOin; go to T6.
- T6 (MUL/DIV only): Zhighout, HIin; retire.
- Retire: instr_cnt increments by 1 (wraps at 2^CNT_W−1 → 0). Next state is T0 if run=1, else IDLE.
- run deasserted mid-instruction does not abort; it is sampled only at retire and in IDLE.
- Latency: ALU op 6 cycles (T0–T5); MUL/DIV 7 cycles (T0–T6); NOP 4 cycles; HALT 4 cycles to the halted flag.
- HALT is left only by clr. HALT is not counted as retired.
- alu_op is nonzero only in T4.
- Gra, Grb and Grc are mutually exclusive. Rin and Rout are never both 1.
- clr asserted at any point, including mid-instruction:
  - state goes to IDLE and instr_cnt goes to 0 immediately;
  - all strobes drop combinationally;
  - no partial retire is counted.
- Simultaneous clr and a clock edge: clr wins.

Decomposition:
- Shared package cpu_pkg:
  - opcode constants (OP_ADD … OP_HALT);
  - state enum (S_IDLE … S_HALT);
  - IR field bit positions (OPC_HI/LO, RA_HI/LO, RB_HI/LO, RC_HI/LO).
- One natural sub-module: seq_decode. It is purely combinational, maps (state, opcode) → strobe vector and next-state hint, and is instantiated once. The state register and counter stay in mul_seq_ctrl.

Test Plan:
- clr=1 then 0, run=1, ir=32'h78918000 (MUL R1,R2,R3):
  - states T0→T6 over 7 clocks; LOin only in T5; HIin only in T6; alu_op=5'b01111 only in T4; instr_cnt=1 after T6.
  - With the datapath, R2=0x12 and R3=0x14 give LO=0x168 and HI=0.
- ir=32'h28918000 (AND), run=1: T0–T5 only; Gra+Rin in T5; next state T0; instr_cnt increments each 6 clocks.
- ir=32'hD8000000 (HALT): after T2, halted=1 in HALT, busy=0, all strobes 0 for 20 further clocks; instr_cnt unchanged.
- MUL in progress, assert clr during T4 (mid-cycle): all strobes 0 within the same cycle; state IDLE; instr_cnt=0; after release with run=1, restart at T0.
- Drop run during T3 of an ADD: instruction completes through T5, then IDLE; busy=0; re-raising run resumes at T0 next clock.
- Unknown opcode 5'b11111: T0–T2, then T3 with no strobes, retire; instr_cnt increments; no Rin, LOin or HIin at any cycle.
